// File: rtl/dht_sensor_ctrl.sv
// Single-wire DHT11/DHT22 controller: host start pulse, 40-bit frame capture,
// checksum test, fixed-point conversion, per-phase timeouts, retries and periodic sampling.
module dht_sensor_ctrl #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int START_LOW_US  = 18_000,
   parameter int TIMEOUT_US    = 100,
   parameter int BIT_THRESH_US = 50,
   parameter int MAX_RETRY     = 3,
   parameter int RETRY_GAP_US  = 1_000_000,
   parameter int PERIOD_US     = 2_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        auto_en,
   input  logic        mode,
   inout  wire         data_io,
   output logic [15:0] humidity,
   output logic [15:0] temperature,
   output logic        valid,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_checksum
);

   localparam int TICK_DIV = (CLK_HZ / 1_000_000 > 0) ? (CLK_HZ / 1_000_000) : 1;
   localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_START_LOW = 4'd1;
   localparam logic [3:0] ST_WAIT_ACK  = 4'd2;
   localparam logic [3:0] ST_ACK_LOW   = 4'd3;
   localparam logic [3:0] ST_ACK_HIGH  = 4'd4;
   localparam logic [3:0] ST_BIT_LOW   = 4'd5;
   localparam logic [3:0] ST_BIT_HIGH  = 4'd6;
   localparam logic [3:0] ST_CHECK     = 4'd7;
   localparam logic [3:0] ST_FAIL      = 4'd8;
   localparam logic [3:0] ST_GAP       = 4'd9;

   logic [DIV_W-1:0] tick_cnt_r;
   logic             tick_s;
   logic [1:0]       sync_r;
   logic             line_prev_r;
   logic             rise_s;
   logic             fall_s;
   logic [3:0]       state_r;
   logic [31:0]      timer_r;
   logic [31:0]      period_cnt_r;
   logic [7:0]       retry_r;
   logic [5:0]       bit_idx_r;
   logic [39:0]      frame_r;
   logic             mode_r;
   logic             fail_cksum_r;
   logic             drive_low_r;
   logic             launch_s;
   logic             period_due_s;
   logic             phase_timeout_s;
   logic             bit_val_s;

   function automatic logic checksum_ok(input logic [39:0] f);
      logic [7:0] sum;
      sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return (sum == f[7:0]);
   endfunction

   function automatic logic [15:0] conv_humidity(input logic [39:0] f, input logic m);
      if (m) begin
         return f[39:24];
      end else begin
         return (16'(f[39:32]) * 16'd10) + 16'(f[31:24]);
      end
   endfunction

   // DHT22 temperature is sign-magnitude on the wire; convert to two's complement
   function automatic logic [15:0] conv_temperature(input logic [39:0] f, input logic m);
      logic [15:0] mag;
      mag = {1'b0, f[22:8]};
      if (m) begin
         return f[23] ? (16'd0 - mag) : mag;
      end else begin
         return (16'(f[23:16]) * 16'd10) + 16'(f[15:8]);
      end
   endfunction

   assign data_io         = drive_low_r ? 1'b0 : 1'bz;
   assign busy            = (state_r != ST_IDLE);
   assign tick_s          = (tick_cnt_r == DIV_W'(TICK_DIV - 1));
   assign rise_s          = sync_r[1] & ~line_prev_r;
   assign fall_s          = ~sync_r[1] & line_prev_r;
   assign period_due_s    = tick_s & (period_cnt_r >= 32'(PERIOD_US - 1));
   assign phase_timeout_s = (timer_r >= 32'(TIMEOUT_US));
   assign bit_val_s       = (timer_r > 32'(BIT_THRESH_US));

   // Launch decision: manual request or period expiry, only honoured from IDLE
   always_comb begin
      launch_s = 1'b0;
      if (state_r == ST_IDLE) begin
         launch_s = start | (auto_en & period_due_s);
      end else begin
         launch_s = 1'b0;
      end
   end

   // 1 us tick divider
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt_r <= '0;
      end else if (tick_s) begin
         tick_cnt_r <= '0;
      end else begin
         tick_cnt_r <= tick_cnt_r + DIV_W'(1);
      end
   end

   // Line synchroniser plus edge history; idles high so release is not seen as an edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r      <= 2'b11;
         line_prev_r <= 1'b1;
      end else begin
         sync_r      <= {sync_r[0], data_io};
         line_prev_r <= sync_r[1];
      end
   end

   // Start-to-start sample period, saturating at the due point
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt_r <= 32'd0;
      end else if (!auto_en || launch_s) begin
         period_cnt_r <= 32'd0;
      end else if (tick_s && (period_cnt_r < 32'(PERIOD_US - 1))) begin
         period_cnt_r <= period_cnt_r + 32'd1;
      end
   end

   // Measurement FSM; waits act on synchronised edges so the host's own pulse
   // still in the synchroniser cannot be mistaken for the sensor acknowledge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         timer_r      <= 32'd0;
         retry_r      <= 8'd0;
         bit_idx_r    <= 6'd0;
         frame_r      <= 40'd0;
         mode_r       <= 1'b0;
         fail_cksum_r <= 1'b0;
         drive_low_r  <= 1'b0;
         humidity     <= 16'd0;
         temperature  <= 16'd0;
         valid        <= 1'b0;
         err_timeout  <= 1'b0;
         err_checksum <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (tick_s) begin
            timer_r <= timer_r + 32'd1;
         end
         case (state_r)
            ST_IDLE: begin
               drive_low_r <= 1'b0;
               if (launch_s) begin
                  state_r      <= ST_START_LOW;
                  drive_low_r  <= 1'b1;
                  timer_r      <= 32'd0;
                  err_timeout  <= 1'b0;
                  err_checksum <= 1'b0;
                  mode_r       <= mode;
                  retry_r      <= 8'd0;
               end
            end
            ST_START_LOW: begin
               if (tick_s && (timer_r >= 32'(START_LOW_US - 1))) begin
                  state_r     <= ST_WAIT_ACK;
                  drive_low_r <= 1'b0;
                  timer_r     <= 32'd0;
               end
            end
            ST_WAIT_ACK, ST_ACK_HIGH: begin
               if (fall_s) begin
                  state_r   <= (state_r == ST_WAIT_ACK) ? ST_ACK_LOW : ST_BIT_LOW;
                  bit_idx_r <= 6'd0;
                  timer_r   <= 32'd0;
               end else if (phase_timeout_s) begin
                  state_r      <= ST_FAIL;
                  fail_cksum_r <= 1'b0;
               end
            end
            ST_ACK_LOW, ST_BIT_LOW: begin
               if (rise_s) begin
                  state_r <= (state_r == ST_ACK_LOW) ? ST_ACK_HIGH : ST_BIT_HIGH;
                  timer_r <= 32'd0;
               end else if (phase_timeout_s) begin
                  state_r      <= ST_FAIL;
                  fail_cksum_r <= 1'b0;
               end
            end
            ST_BIT_HIGH: begin
               if (fall_s) begin
                  frame_r   <= {frame_r[38:0], bit_val_s};
                  bit_idx_r <= bit_idx_r + 6'd1;
                  timer_r   <= 32'd0;
                  state_r   <= (bit_idx_r == 6'd39) ? ST_CHECK : ST_BIT_LOW;
               end else if (phase_timeout_s) begin
                  state_r      <= ST_FAIL;
                  fail_cksum_r <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (checksum_ok(frame_r)) begin
                  humidity    <= conv_humidity(frame_r, mode_r);
                  temperature <= conv_temperature(frame_r, mode_r);
                  valid       <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r      <= ST_FAIL;
                  fail_cksum_r <= 1'b1;
               end
            end
            ST_FAIL: begin
               timer_r <= 32'd0;
               if (retry_r < 8'(MAX_RETRY)) begin
                  retry_r <= retry_r + 8'd1;
                  state_r <= ST_GAP;
               end else begin
                  err_checksum <= err_checksum | fail_cksum_r;
                  err_timeout  <= err_timeout | ~fail_cksum_r;
                  state_r      <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (tick_s && (timer_r >= 32'(RETRY_GAP_US - 1))) begin
                  state_r     <= ST_START_LOW;
                  drive_low_r <= 1'b1;
                  timer_r     <= 32'd0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               drive_low_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Directed bench for dht_sensor_ctrl: behavioural sensor on an open-drain line,
// table of frames with hand-computed results, plus retry/timeout/reset/auto sequences.
module tb_dht_sensor_ctrl;

   localparam int START_LOW = 200;
   localparam int TOUT      = 100;
   localparam int THRESH    = 50;
   localparam int RETRIES   = 3;
   localparam int GAP       = 300;
   localparam int PERIOD    = 4500;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        auto_en = 1'b0;
   logic        mode = 1'b0;
   logic        sensor_low = 1'b0;
   wire         data_io;
   logic [15:0] humidity;
   logic [15:0] temperature;
   logic        valid;
   logic        busy;
   logic        err_timeout;
   logic        err_checksum;

   assign data_io = sensor_low ? 1'b0 : 1'bz;
   pullup (data_io);

   always #5 clk = ~clk;

   dht_sensor_ctrl #(
      .CLK_HZ(1_000_000), .START_LOW_US(START_LOW), .TIMEOUT_US(TOUT),
      .BIT_THRESH_US(THRESH), .MAX_RETRY(RETRIES), .RETRY_GAP_US(GAP), .PERIOD_US(PERIOD)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .auto_en(auto_en), .mode(mode),
      .data_io(data_io), .humidity(humidity), .temperature(temperature), .valid(valid),
      .busy(busy), .err_timeout(err_timeout), .err_checksum(err_checksum)
   );

   int n_pass = 0;
   int n_checks = 0;

   // Line / output monitor sampled on the falling edge
   logic        host_now;
   logic        host_prev = 1'b0;
   int          cyc = 0;
   int          pulse_cnt = 0;
   int          pulse_cyc [64];
   int          last_pulse_cyc = 0;
   int          last_width = 0;
   int          last_rel_cyc = 0;
   int          valid_cnt = 0;
   logic [15:0] hum_at_valid = 16'd0;
   logic [15:0] temp_at_valid = 16'd0;

   assign host_now = (data_io === 1'b0) && !sensor_low;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (host_now && !host_prev) begin
         if (pulse_cnt < 64) pulse_cyc[pulse_cnt] <= cyc;
         pulse_cnt      <= pulse_cnt + 1;
         last_pulse_cyc <= cyc;
      end
      if (!host_now && host_prev) begin
         last_width   <= cyc - last_pulse_cyc;
         last_rel_cyc <= cyc;
      end
      host_prev <= host_now;
      if (valid) begin
         valid_cnt     <= valid_cnt + 1;
         hum_at_valid  <= humidity;
         temp_at_valid <= temperature;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic m);
      mode  = m;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // Sensor: waits for the host pulse, acks 80/80 us, sends nbits MSB first, then a 50 us end low
   task automatic sensor_reply(input logic [39:0] frame, input int nbits, input int budget);
      int n;
      n = 0;
      while (!host_now && n < budget) begin step(1); n++; end
      check("host start seen", 32'(host_now), 32'd1);
      if (!host_now) return;
      n = 0;
      while (host_now && n < START_LOW + 20) begin step(1); n++; end
      check("host release seen", 32'(host_now), 32'd0);
      step(30);
      sensor_low = 1'b1; step(80);
      sensor_low = 1'b0; step(80);
      for (int i = 0; i < nbits; i++) begin
         sensor_low = 1'b1; step(50);
         sensor_low = 1'b0; step(frame[39-i] ? 70 : 26);
      end
      if (nbits == 40) begin
         sensor_low = 1'b1; step(50);
         sensor_low = 1'b0;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin step(1); n++; end
      check("busy falls", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        m;
      logic [39:0] frame;
      logic [15:0] hum;
      logic [15:0] temp;
   } vec_t;

   vec_t vecs [6];
   int   p0;
   int   v0;
   int   d;
   logic busy_at_inject;

   initial begin
      vecs[0] = '{1'b0, 40'h30_00_17_00_47, 16'd480,  16'd230};
      vecs[1] = '{1'b0, 40'h28_05_19_09_4F, 16'd405,  16'd259};
      vecs[2] = '{1'b1, 40'h01_F4_00_FA_EF, 16'd500,  16'd250};
      vecs[3] = '{1'b1, 40'h00_00_FF_FF_FE, 16'd0,    16'h8001};
      vecs[4] = '{1'b1, 40'h03_E8_80_00_6B, 16'd1000, 16'h0000};
      vecs[5] = '{1'b1, 40'h02_8C_80_65_73, 16'd652,  16'hFF9B};

      #2 reset = 1'b0;
      step(5);
      check("reset humidity", 32'(humidity), 32'd0);
      check("reset temperature", 32'(temperature), 32'd0);
      check("reset valid", 32'(valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset err_timeout", 32'(err_timeout), 32'd0);
      check("reset err_checksum", 32'(err_checksum), 32'd0);
      check("reset line released", 32'(data_io === 1'b1), 32'd1);
      reset = 1'b1;
      step(5);

      // Table of good frames; mode is flipped after launch to prove it is latched
      for (int k = 0; k < 6; k++) begin
         v0 = valid_cnt;
         do_start(vecs[k].m);
         mode = ~vecs[k].m;
         sensor_reply(vecs[k].frame, 40, 50);
         wait_idle(500);
         check("vec valid pulses", 32'(valid_cnt - v0), 32'd1);
         check("vec humidity", 32'(humidity), 32'(vecs[k].hum));
         check("vec temperature", 32'(temperature), 32'(vecs[k].temp));
         check("vec humidity with valid", 32'(hum_at_valid), 32'(vecs[k].hum));
         check("vec temperature with valid", 32'(temp_at_valid), 32'(vecs[k].temp));
         check("vec err_checksum", 32'(err_checksum), 32'd0);
         check("vec err_timeout", 32'(err_timeout), 32'd0);
         if (k == 0) check("start pulse width", 32'(last_width), 32'(START_LOW));
      end

      // Persistent bad checksum: every attempt fails, outputs hold
      p0 = pulse_cnt; v0 = valid_cnt;
      do_start(1'b0);
      for (int a = 0; a <= RETRIES; a++) sensor_reply(40'h30_00_17_00_48, 40, GAP + START_LOW + 100);
      wait_idle(500);
      check("cksum start pulses", 32'(pulse_cnt - p0), 32'(RETRIES + 1));
      check("cksum err_checksum", 32'(err_checksum), 32'd1);
      check("cksum err_timeout", 32'(err_timeout), 32'd0);
      check("cksum no valid", 32'(valid_cnt - v0), 32'd0);
      check("cksum humidity held", 32'(humidity), 32'd652);
      check("cksum temperature held", 32'(temperature), 32'hFF9B);

      // Silent sensor: each attempt times out after release
      p0 = pulse_cnt; v0 = valid_cnt;
      do_start(1'b0);
      wait_idle((RETRIES + 1) * (START_LOW + TOUT + GAP + 10));
      d = cyc - last_rel_cyc;
      check("timeout start pulses", 32'(pulse_cnt - p0), 32'(RETRIES + 1));
      check("timeout err_timeout", 32'(err_timeout), 32'd1);
      check("timeout err_checksum cleared", 32'(err_checksum), 32'd0);
      check("timeout no valid", 32'(valid_cnt - v0), 32'd0);
      check("timeout humidity held", 32'(humidity), 32'd652);
      check_range("timeout latency", d, TOUT, TOUT + 4);

      // Reset while the host drives the start pulse
      do_start(1'b0);
      step(10);
      check("host driving before reset", 32'(host_now), 32'd1);
      reset = 1'b0;
      #1;
      check("line released on reset", 32'(data_io === 1'b1), 32'd1);
      check("busy cleared on reset", 32'(busy), 32'd0);
      check("err_timeout cleared on reset", 32'(err_timeout), 32'd0);
      step(3);
      reset = 1'b1;
      step(5);

      // Reset after bit 20, then a clean frame
      v0 = valid_cnt;
      do_start(1'b0);
      sensor_reply(40'h30_00_17_00_47, 40, 50);
      wait_idle(500);
      do_start(1'b1);
      sensor_reply(40'h02_8C_80_65_73, 21, 50);
      reset = 1'b0;
      #1;
      check("midframe humidity 0", 32'(humidity), 32'd0);
      check("midframe temperature 0", 32'(temperature), 32'd0);
      check("midframe busy 0", 32'(busy), 32'd0);
      check("midframe line high", 32'(data_io === 1'b1), 32'd1);
      step(3);
      reset = 1'b1;
      step(5);
      check("midframe no partial valid", 32'(valid_cnt - v0), 32'd1);
      v0 = valid_cnt;
      do_start(1'b0);
      sensor_reply(40'h30_00_17_00_47, 40, 50);
      wait_idle(500);
      check("post reset valid", 32'(valid_cnt - v0), 32'd1);
      check("post reset humidity", 32'(humidity), 32'd480);
      check("post reset temperature", 32'(temperature), 32'd230);

      // Periodic sampling with a start request injected mid-frame
      p0 = pulse_cnt; v0 = valid_cnt;
      busy_at_inject = 1'b0;
      mode = 1'b0;
      auto_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin
            fork
               sensor_reply(40'h30_00_17_00_47, 40, PERIOD + 500);
               begin
                  step(1500);
                  busy_at_inject = busy;
                  start = 1'b1;
                  step(1);
                  start = 1'b0;
               end
            join
         end else begin
            sensor_reply(40'h30_00_17_00_47, 40, PERIOD + 500);
         end
      end
      auto_en = 1'b0;
      step(PERIOD + 200);
      check("auto inject while busy", 32'(busy_at_inject), 32'd1);
      check("auto start pulses", 32'(pulse_cnt - p0), 32'd3);
      check("auto valid pulses", 32'(valid_cnt - v0), 32'd3);
      if (p0 + 2 < 64) begin
         check("auto spacing 1", 32'(pulse_cyc[p0 + 1] - pulse_cyc[p0]), 32'(PERIOD));
         check("auto spacing 2", 32'(pulse_cyc[p0 + 2] - pulse_cyc[p0 + 1]), 32'(PERIOD));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
